// File: rtl/timer_bank.sv
// Bank of independent tick timers: each channel has its own prescaler, so its tick phase
// is aligned to its own start. Channels support one-shot or periodic expiry against a latched limit.
module timer_bank #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TICK_FREQ = 1_000,
    parameter int N_CH      = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         start_i,
    input  logic [N_CH-1:0]         stop_i,
    input  logic [N_CH-1:0]         clr_i,
    input  logic [N_CH-1:0]         mode_i,
    input  logic [N_CH*CNT_W-1:0]   limit_i,
    output logic [N_CH*CNT_W-1:0]   count_o,
    output logic [N_CH-1:0]         running_o,
    output logic [N_CH-1:0]         expire_o
);

    localparam int DIV = (TICK_FREQ > 0) ? CLK_FREQ / TICK_FREQ : 0;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (TICK_FREQ < 1 || DIV < 1 || (CLK_FREQ % TICK_FREQ) != 0 || N_CH < 1 || CNT_W < 1) begin : g_bad_param
        $error("timer_bank: CLK_FREQ/TICK_FREQ must be an integer >= 1, N_CH and CNT_W >= 1");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [PW-1:0]    pre;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] lim;
        logic [CNT_W-1:0] lim_in;
        logic             mode;
        logic             run;
        logic             expire;

        assign lim_in = limit_i[c*CNT_W +: CNT_W];

        // Priority per edge: rst > clr > start > stop > tick.
        always_ff @(posedge clk) begin
            if (rst) begin
                pre    <= '0;
                cnt    <= '0;
                lim    <= '0;
                mode   <= 1'b0;
                run    <= 1'b0;
                expire <= 1'b0;
            end else if (clr_i[c]) begin
                pre    <= '0;
                cnt    <= '0;
                run    <= 1'b0;
                expire <= 1'b0;
            end else if (start_i[c]) begin
                pre    <= '0;
                cnt    <= '0;
                lim    <= lim_in;
                mode   <= mode_i[c];
                run    <= (lim_in != '0);
                // A zero limit expires immediately instead of running.
                expire <= (lim_in == '0);
            end else if (stop_i[c]) begin
                run    <= 1'b0;
                expire <= 1'b0;
            end else begin
                expire <= 1'b0;
                if (run) begin
                    if (pre == PW'(DIV - 1)) begin
                        pre <= '0;
                        if (cnt == lim - CNT_W'(1)) begin
                            expire <= 1'b1;
                            if (mode) begin
                                cnt <= '0;
                            end else begin
                                cnt <= lim;
                                run <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end
            end
        end

        assign count_o[c*CNT_W +: CNT_W] = cnt;
        assign running_o[c]              = run;
        assign expire_o[c]               = expire;
    end

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus random strobes, checked every cycle against
// an elapsed-time reference model through an expected-value queue.
module tb_timer_bank;

    localparam int DIV = 4;
    localparam int NC  = 2;
    localparam int CW  = 4;
    localparam int W   = NC*CW + 2*NC;

    logic             clk;
    logic             rst;
    logic [NC-1:0]    start_i, stop_i, clr_i, mode_i;
    logic [NC*CW-1:0] limit_i;
    logic [NC*CW-1:0] count_o;
    logic [NC-1:0]    running_o, expire_o;

    timer_bank #(.CLK_FREQ(4), .TICK_FREQ(1), .N_CH(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clr_i(clr_i),
        .mode_i(mode_i), .limit_i(limit_i), .count_o(count_o),
        .running_o(running_o), .expire_o(expire_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: a running channel's outputs follow from edges elapsed since its start.
    int t_edge = 0;
    int m_run[NC], m_e0[NC], m_lim[NC], m_mode[NC], m_hold[NC], m_exp[NC];

    function automatic int count_at(int c, int n);
        if (m_mode[c] != 0) return (n / DIV) % m_lim[c];
        if (n >= m_lim[c] * DIV) return m_lim[c];
        return n / DIV;
    endfunction

    task automatic model_step(input logic r, input logic [NC-1:0] st, sp, cl, md,
                              input logic [NC*CW-1:0] lim);
        logic [W-1:0] e;
        int n;
        t_edge++;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            if (r || cl[c]) begin
                m_run[c] = 0; m_hold[c] = 0; m_exp[c] = 0;
            end else if (st[c]) begin
                m_e0[c]   = t_edge;
                m_lim[c]  = int'(lim[c*CW +: CW]);
                m_mode[c] = int'(md[c]);
                m_hold[c] = 0;
                m_run[c]  = (m_lim[c] != 0) ? 1 : 0;
                m_exp[c]  = (m_lim[c] == 0) ? 1 : 0;
            end else if (sp[c]) begin
                if (m_run[c] != 0) m_hold[c] = count_at(c, t_edge - 1 - m_e0[c]);
                m_run[c] = 0; m_exp[c] = 0;
            end else begin
                m_exp[c] = 0;
                if (m_run[c] != 0) begin
                    n = t_edge - m_e0[c];
                    if (n % (m_lim[c] * DIV) == 0) begin
                        m_exp[c] = 1;
                        if (m_mode[c] == 0) begin
                            m_hold[c] = m_lim[c];
                            m_run[c]  = 0;
                        end
                    end
                end
            end
            e[c*CW +: CW]    = (m_run[c] != 0) ? CW'(count_at(c, t_edge - m_e0[c])) : CW'(m_hold[c]);
            e[NC*CW + c]     = (m_run[c] != 0);
            e[NC*CW + NC + c] = (m_exp[c] != 0);
        end
        exp_q.push_back(e);
    endtask

    // Driver tasks
    task automatic cyc(input logic r, input logic [NC-1:0] st, sp, cl, md,
                       input logic [NC*CW-1:0] lim);
        @(negedge clk);
        rst = r; start_i = st; stop_i = sp; clr_i = cl; mode_i = md; limit_i = lim;
        model_step(r, st, sp, cl, md, lim);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0, '0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (count_o !== e[NC*CW-1:0]) begin
                    errors++;
                    $display("FAIL count t=%0t got=%h exp=%h", $time, count_o, e[NC*CW-1:0]);
                end
                checks++;
                if (running_o !== e[NC*CW +: NC]) begin
                    errors++;
                    $display("FAIL running t=%0t got=%b exp=%b", $time, running_o, e[NC*CW +: NC]);
                end
                checks++;
                if (expire_o !== e[NC*CW+NC +: NC]) begin
                    errors++;
                    $display("FAIL expire t=%0t got=%b exp=%b", $time, expire_o, e[NC*CW+NC +: NC]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [NC-1:0]    st, sp, cl, md;
        logic [NC*CW-1:0] lim;
        logic             r;
        rst = 1'b1; start_i = '0; stop_i = '0; clr_i = '0; mode_i = '0; limit_i = '0;
        for (int c = 0; c < NC; c++) begin
            m_run[c] = 0; m_e0[c] = 0; m_lim[c] = 0; m_mode[c] = 0; m_hold[c] = 0; m_exp[c] = 0;
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, '0, '0, '0, '0, '0);

        // One-shot ch0 limit 3
        cyc(1'b0, 2'b01, '0, '0, 2'b00, {4'd0, 4'd3});
        idle(18);
        // Periodic ch1 limit 2
        cyc(1'b0, 2'b10, '0, '0, 2'b10, {4'd2, 4'd0});
        idle(28);
        cyc(1'b0, '0, '0, 2'b10, '0, '0);
        // Stop ch0 (limit 5) at E0+6, then restart
        cyc(1'b0, 2'b01, '0, '0, 2'b00, {4'd0, 4'd5});
        idle(5);
        cyc(1'b0, '0, 2'b01, '0, '0, '0);
        idle(25);
        cyc(1'b0, 2'b01, '0, '0, 2'b00, {4'd0, 4'd5});
        idle(6);
        // Same-edge start+clr, then start+stop
        cyc(1'b0, 2'b01, '0, 2'b01, 2'b00, {4'd0, 4'd4});
        idle(3);
        cyc(1'b0, 2'b01, 2'b01, '0, 2'b00, {4'd0, 4'd4});
        idle(20);
        // Limit 0 in both modes, then max limit
        cyc(1'b0, 2'b01, '0, '0, 2'b00, {4'd0, 4'd0});
        idle(4);
        cyc(1'b0, 2'b10, '0, '0, 2'b10, {4'd0, 4'd0});
        idle(4);
        cyc(1'b0, 2'b01, '0, '0, 2'b00, {4'd0, 4'd15});
        idle(64);
        // Staggered channels, then reset mid-run
        cyc(1'b0, 2'b01, '0, '0, 2'b01, {4'd0, 4'd3});
        idle(2);
        cyc(1'b0, 2'b10, '0, '0, 2'b00, {4'd5, 4'd0});
        idle(6);
        cyc(1'b1, '0, '0, '0, '0, '0);
        idle(12);

        // Random strobes
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < NC; c++) begin
                st[c] = ($urandom_range(0, 24) == 0);
                sp[c] = ($urandom_range(0, 39) == 0);
                cl[c] = ($urandom_range(0, 79) == 0);
                md[c] = $urandom_range(0, 1);
                lim[c*CW +: CW] = CW'($urandom_range(0, 15));
            end
            cyc(r, st, sp, cl, md, lim);
        end
        idle(3);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel millisecond-class timer bank: N_CH independent channels, each counting ticks of a configurable rate derived from the system clock, with one-shot or periodic expiry and a per-channel limit. It generalises the single free-running ms counter used across the receiver design. Consumers include detection-window timeouts, LED/beep cadence, and periodic housekeeping strobes. Each channel has its own prescaler, so tick phase is aligned to that channel's start.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- TICK_FREQ, 1_000: tick rate in Hz. DIV = CLK_FREQ/TICK_FREQ must be an integer >= 1; otherwise elaboration error.
- N_CH, 4: number of channels, >= 1.
- CNT_W, 16: count/limit width per channel, >= 1.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  N_CH  per-channel start/restart strobe; samples limit_i and mode_i for that channel.
- stop_i  in  N_CH  per-channel pause strobe; freezes count and prescaler.
- clr_i  in  N_CH  per-channel synchronous clear.
- mode_i  in  N_CH  0 = one-shot, 1 = periodic; sampled on start.
- limit_i  in  N_CH*CNT_W  channel c at bits [c*CNT_W +: CNT_W]; sampled on start.
- count_o  out  N_CH*CNT_W  current tick count per channel, same packing.
- running_o  out  N_CH  channel is counting.
- expire_o  out  N_CH  one-cycle pulse on expiry.

## Operation
- Per-channel state: prescaler (clog2(DIV) bits, min 1), count, latched limit, latched mode, running, expire.
- Reset: all count_o = 0, running_o = 0, expire_o = 0, prescalers = 0, latched limit/mode = 0.
- Per-channel priority, evaluated each edge: rst > clr > start > stop > tick.
- clr: count 0, prescaler 0, running 0, expire 0.
- start: count 0, prescaler 0, latch limit and mode. If latched limit != 0, running 1. If limit == 0, running stays 0 and expire pulses next cycle, in either mode. Start while running restarts the channel.
- stop: running 0; count and prescaler hold. A new start restarts from 0; there is no resume.
- While running, each edge: if prescaler == DIV-1, prescaler 0 and tick; else prescaler + 1.
- On tick, if count == limit-1 (expiry):
  - one-shot: count = limit, running 0, expire pulses.
  - periodic: count = 0, running stays 1, expire pulses.
- On tick otherwise: count + 1.
- A stop strobe on the expiry edge wins: no expire, and count holds.
- Idle or stopped channels keep count_o held.
- expire is a register: high for exactly one cycle, then cleared the next edge unless re-asserted.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Let E0 be the edge that samples start. Then running_o = 1 in the cycle after E0.
- Tick k occurs at edge E0 + k*DIV; count_o = k after that edge.
- Expiry occurs at edge E0 + limit*DIV. expire_o is high in the cycle after it, coincident with count_o = limit (one-shot) or 0 (periodic).
- Periodic mode: expire pulses every limit*DIV cycles with no slip.
- DIV = 1: ticks on every running edge.
- Start with limit 0: expire_o high in the cycle after E0.
- All outputs are registered; there is no combinational input-to-output path.
- Reset or clr takes effect on the sampling edge. Outputs are at reset values in the following cycle, including a pulse that would otherwise be emitted.

## Test plan
- Common setup: CLK_FREQ = 4, TICK_FREQ = 1 (DIV = 4), N_CH = 2, CNT_W = 4.
- One-shot, ch0, limit 3, start at E0 -> count_o 1/2/3 after E0+4/8/12; expire_o high only in the cycle after E0+12; running_o falls then; count holds 3.
- Periodic, ch1, limit 2 -> expire_o pulses after E0+8, E0+16 and E0+24; count_o sequence 1, 0, 1, 0; running_o stays 1.
- Stop after E0+6 on ch0 (limit 5) -> count_o stays 1 indefinitely and no expire. Restart at E1 -> count_o 1 after E1+4.
- Same-edge start and clr on ch0 -> clr wins: running_o 0, count 0. Same-edge start and stop -> start wins.
- Start with limit 0 -> expire_o high for one cycle after E0, running_o stays 0. Start with limit 15 (max) -> expire after E0+60, count_o = 15.
- rst asserted at E0+10 while both channels run -> all outputs 0 the next cycle; no expire for at least 4 cycles after rst deasserts without a new start. Channel independence is checked by running both channels with staggered starts.
